// File: rtl/trigger_capture_pkg.sv
// Shared definitions for the trigger capture buffer: event codes, FSM states
// and configuration bus addresses.
package trigger_capture_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_START = 2'b01,
    EVT_TRIG  = 2'b10,
    EVT_ABORT = 2'b11
  } evt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_POST,
    ST_READ
  } state_e;

  localparam int unsigned ADDR_PRE  = 0;
  localparam int unsigned ADDR_PST  = 1;
  localparam int unsigned ADDR_CTRL = 2;

endpackage

// File: rtl/trigger_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Contents are never cleared.
module trigger_capture_ram
  import trigger_capture_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/trigger_capture.sv
// Pre/post-trigger capture buffer: records an event-annotated sample stream
// into a ring RAM and replays the captured window with trigger/last markers.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int unsigned BDW = 32,
  parameter int unsigned BAW = 6,
  parameter int unsigned SDW = 32,
  parameter int unsigned DAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [1:0]     sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic           sto_ttrig,
  output logic [SDW-1:0] sto_tdata,
  output logic           sts_busy
);

  localparam logic [DAW+1:0] FULL = (DAW+2)'(2**DAW);

  state_e         state_q, state_d;
  logic [DAW-1:0] cfg_pre_q;
  logic [DAW:0]   cfg_pst_q;
  logic [DAW-1:0] pre_q, pre_d;
  logic [DAW:0]   pst_q, pst_d;
  logic [DAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DAW-1:0] trg_ptr_q, trg_ptr_d;
  logic [DAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DAW-1:0] pre_cnt_q, pre_cnt_d;
  logic [DAW:0]   pst_cnt_q, pst_cnt_d;
  logic [DAW:0]   rd_rem_q, rd_rem_d;
  logic [DAW:0]   pst_next;

  logic           clr, in_acc, wr_en, rd_start, rd_issue, pop;
  logic           trig_done, post_done, iss_trig, iss_last;
  logic [2:0]     occ;
  logic [SDW-1:0] ram_rdata;
  evt_e           evt;
  logic           unused_wdata;

  logic           ram_v_q, ram_trig_q, ram_last_q;
  logic           out_v_q, out_trig_q, out_last_q;
  logic [SDW-1:0] out_data_q;
  logic           skid_v_q, skid_trig_q, skid_last_q;
  logic [SDW-1:0] skid_data_q;

  assign bus_wready   = 1'b1;
  assign unused_wdata = ^bus_wdata[BDW-1:DAW+1];
  assign clr    = bus_wvalid && (bus_waddr == BAW'(ADDR_CTRL)) && bus_wdata[0];
  assign in_acc = sti_tvalid && sti_tready && !clr;
  assign evt    = evt_e'(sti_tevent);

  assign sti_tready = (state_q != ST_READ);
  assign sts_busy   = (state_q != ST_IDLE);
  assign sto_tvalid = out_v_q;
  assign sto_tlast  = out_last_q;
  assign sto_ttrig  = out_trig_q;
  assign sto_tdata  = out_data_q;

  // Window closes when the post count is met or history+post fills the ring.
  assign pst_next  = pst_cnt_q + (DAW+1)'(1);
  assign trig_done = (pst_q == (DAW+1)'(1)) ||
                     ((DAW+2)'(pre_cnt_q) + (DAW+2)'(1) == FULL);
  assign post_done = (pst_next == pst_q) ||
                     ((DAW+2)'(pre_cnt_q) + (DAW+2)'(pst_next) == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pre_q <= '0;
      cfg_pst_q <= '0;
    end else if (bus_wvalid) begin
      if (bus_waddr == BAW'(ADDR_PRE)) cfg_pre_q <= bus_wdata[DAW-1:0];
      if (bus_waddr == BAW'(ADDR_PST)) cfg_pst_q <= bus_wdata[DAW:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    pst_d     = pst_q;
    wr_ptr_d  = wr_ptr_q;
    trg_ptr_d = trg_ptr_q;
    pre_cnt_d = pre_cnt_q;
    pst_cnt_d = pst_cnt_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_acc && evt == EVT_START) begin
          pre_d     = cfg_pre_q;
          pst_d     = (cfg_pst_q == '0) ? (DAW+1)'(1) : cfg_pst_q;
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + DAW'(1);
          pre_cnt_d = DAW'(1);
          pst_cnt_d = '0;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_acc) begin
          if (evt == EVT_ABORT) begin
            state_d = ST_IDLE;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + DAW'(1);
            if (evt == EVT_TRIG) begin
              trg_ptr_d = wr_ptr_q;
              pst_cnt_d = (DAW+1)'(1);
              state_d   = trig_done ? ST_READ : ST_POST;
            end else if (pre_cnt_q < pre_q) begin
              pre_cnt_d = pre_cnt_q + DAW'(1);
            end
          end
        end
      end
      ST_POST: begin
        if (in_acc) begin
          if (evt == EVT_ABORT) begin
            state_d = ST_IDLE;
          end else begin
            wr_en     = 1'b1;
            wr_ptr_d  = wr_ptr_q + DAW'(1);
            pst_cnt_d = pst_next;
            if (post_done) state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (pop && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  assign rd_start = in_acc && (state_d == ST_READ) && (state_q != ST_READ);

  // Reads are issued only while the out/skid pair can absorb every read in flight.
  assign pop      = out_v_q && sto_tready;
  assign occ      = 3'(out_v_q) + 3'(skid_v_q) + 3'(ram_v_q);
  assign rd_issue = (state_q == ST_READ) && (rd_rem_q != '0) && (occ <= 3'(pop) + 3'd1);
  assign iss_trig = (rd_ptr_q == trg_ptr_q);
  assign iss_last = (rd_rem_q == (DAW+1)'(1));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    rd_rem_d = rd_rem_q;
    if (clr) begin
      rd_rem_d = '0;
    end else if (rd_start) begin
      rd_ptr_d = trg_ptr_d - pre_cnt_d;
      rd_rem_d = (DAW+1)'(pre_cnt_d) + pst_cnt_d;
    end else if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + DAW'(1);
      rd_rem_d = rd_rem_q - (DAW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      pst_q     <= '0;
      wr_ptr_q  <= '0;
      trg_ptr_q <= '0;
      rd_ptr_q  <= '0;
      pre_cnt_q <= '0;
      pst_cnt_q <= '0;
      rd_rem_q  <= '0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      pst_q     <= pst_d;
      wr_ptr_q  <= wr_ptr_d;
      trg_ptr_q <= trg_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pre_cnt_q <= pre_cnt_d;
      pst_cnt_q <= pst_cnt_d;
      rd_rem_q  <= rd_rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_v_q     <= 1'b0;
      ram_trig_q  <= 1'b0;
      ram_last_q  <= 1'b0;
      out_v_q     <= 1'b0;
      out_trig_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_trig_q <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else if (clr) begin
      ram_v_q  <= 1'b0;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      ram_v_q    <= rd_issue;
      ram_trig_q <= iss_trig;
      ram_last_q <= iss_last;
      if (pop) begin
        if (skid_v_q) begin
          out_data_q <= skid_data_q;
          out_trig_q <= skid_trig_q;
          out_last_q <= skid_last_q;
          skid_v_q   <= ram_v_q;
          if (ram_v_q) begin
            skid_data_q <= ram_rdata;
            skid_trig_q <= ram_trig_q;
            skid_last_q <= ram_last_q;
          end
        end else if (ram_v_q) begin
          out_data_q <= ram_rdata;
          out_trig_q <= ram_trig_q;
          out_last_q <= ram_last_q;
        end else begin
          out_v_q <= 1'b0;
        end
      end else if (ram_v_q) begin
        if (!out_v_q) begin
          out_v_q    <= 1'b1;
          out_data_q <= ram_rdata;
          out_trig_q <= ram_trig_q;
          out_last_q <= ram_last_q;
        end else begin
          skid_v_q    <= 1'b1;
          skid_data_q <= ram_rdata;
          skid_trig_q <= ram_trig_q;
          skid_last_q <= ram_last_q;
        end
      end
    end
  end

  trigger_capture_ram #(
    .AW(DAW),
    .DW(SDW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(sti_tdata),
    .re_i   (rd_issue),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: stimulus pushes expected replay samples,
// a negedge monitor pops and compares each output transfer and checks stalls.
module tb_trigger_capture;
  import trigger_capture_pkg::*;

  localparam int unsigned DAW = 4;

  typedef struct packed {
    logic        trig;
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wready, bus_wvalid;
  logic [5:0]  bus_waddr;
  logic [31:0] bus_wdata;
  logic        sti_tready, sti_tvalid;
  logic [1:0]  sti_tevent;
  logic [31:0] sti_tdata;
  logic        sto_tready, sto_tvalid, sto_tlast, sto_ttrig;
  logic [31:0] sto_tdata;
  logic        sts_busy;

  exp_t exp_q[$];
  exp_t hold_x;
  bit   hold_v = 1'b0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  trigger_capture #(
    .BDW(32),
    .BAW(6),
    .SDW(32),
    .DAW(DAW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_wready(bus_wready),
    .bus_wvalid(bus_wvalid),
    .bus_waddr (bus_waddr),
    .bus_wdata (bus_wdata),
    .sti_tready(sti_tready),
    .sti_tvalid(sti_tvalid),
    .sti_tevent(sti_tevent),
    .sti_tdata (sti_tdata),
    .sto_tready(sto_tready),
    .sto_tvalid(sto_tvalid),
    .sto_tlast (sto_tlast),
    .sto_ttrig (sto_ttrig),
    .sto_tdata (sto_tdata),
    .sts_busy  (sts_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [31:0] d, input bit t, input bit l);
    exp_q.push_back({t, l, d});
  endtask

  // Monitor: values seen at negedge are what the next posedge transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_v)
        check("stall_hold", {sto_tvalid, sto_ttrig, sto_tlast, sto_tdata}, {1'b1, hold_x});
      hold_v = 1'b0;
      if (sto_tvalid) begin
        if (sto_tready) begin
          if (exp_q.size() == 0)
            check("unexpected_out", {sto_ttrig, sto_tlast, sto_tdata}, 64'hDEAD_0000_0000);
          else
            check("out_sample", {sto_ttrig, sto_tlast, sto_tdata}, exp_q.pop_front());
        end else begin
          hold_v = 1'b1;
          hold_x = {sto_ttrig, sto_tlast, sto_tdata};
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    tick();
    bus_wvalid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] e);
    bit ok = 1'b0;
    int unsigned n = 0;
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    sti_tevent = e;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = sti_tready;
      tick();
      n++;
    end
    sti_tvalid = 1'b0;
    sti_tevent = EVT_NONE;
    check("send_accept", ok, 1);
  endtask

  task automatic wait_done(input string name, input bit rnd);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || sts_busy) && n < 500) begin
      if (rnd) sto_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    sto_tready = 1'b1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, {sts_busy, sti_tready}, 2'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus_wvalid = 1'b0; bus_waddr = '0; bus_wdata = '0;
    sti_tvalid = 1'b0; sti_tevent = EVT_NONE; sti_tdata = '0; sto_tready = 1'b1;
    repeat (3) tick();
    check("rst_outputs", {sto_tvalid, sto_tlast, sto_ttrig, sto_tdata}, '0);
    check("rst_status", {sti_tready, sts_busy, bus_wready}, 3'b101);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // pre=4 pst=3, start 0x10, trigger 0x1A
    bus_write(6'd0, 32'd4);
    bus_write(6'd1, 32'd3);
    for (int d = 'h16; d <= 'h1C; d++) expect_out(d, d == 'h1A, d == 'h1C);
    send(32'h10, EVT_START);
    for (int d = 'h11; d <= 'h19; d++) send(d, EVT_NONE);
    send(32'h1A, EVT_TRIG);
    send(32'h1B, EVT_NONE);
    send(32'h1C, EVT_NONE);
    check("t1_tready_drop", {sti_tready, sto_tvalid}, 2'b00);
    tick();
    check("t1_lat1", sto_tvalid, 0);
    tick();
    check("t1_lat2", sto_tvalid, 1);
    wait_done("t1", 1'b0);

    // pre=8 pst=2, short history; trigger/abort ignored in IDLE
    bus_write(6'd0, 32'd8);
    bus_write(6'd1, 32'd2);
    send(32'hEE, EVT_TRIG);
    send(32'hEF, EVT_ABORT);
    check("t2_idle_ignore", sts_busy, 0);
    for (int d = 0; d <= 4; d++) expect_out(d, d == 3, d == 4);
    send(32'h00, EVT_START);
    send(32'h01, EVT_NONE);
    send(32'h02, EVT_NONE);
    send(32'h03, EVT_TRIG);
    send(32'h04, EVT_NONE);
    wait_done("t2", 1'b0);

    // cfg_pst=0 acts as 1: trigger sample closes the window
    bus_write(6'd0, 32'd2);
    bus_write(6'd1, 32'd0);
    for (int d = 'hA0; d <= 'hA2; d++) expect_out(d, d == 'hA2, d == 'hA2);
    send(32'hA0, EVT_START);
    send(32'hA1, EVT_NONE);
    send(32'hA2, EVT_TRIG);
    wait_done("t2b", 1'b0);

    // abort in POST, then a window with a shadowed config write mid-FILL
    bus_write(6'd0, 32'd4);
    bus_write(6'd1, 32'd3);
    send(32'h30, EVT_START);
    send(32'h31, EVT_NONE);
    send(32'h32, EVT_TRIG);
    send(32'h33, EVT_NONE);
    send(32'h34, EVT_ABORT);
    repeat (3) tick();
    check("t3_abort", {sto_tvalid, sts_busy, sti_tready}, 3'b001);
    for (int d = 'h40; d <= 'h45; d++) expect_out(d, d == 'h43, d == 'h45);
    send(32'h40, EVT_START);
    send(32'h41, EVT_NONE);
    bus_write(6'd1, 32'd1);
    send(32'h42, EVT_NONE);
    send(32'h43, EVT_TRIG);
    send(32'h44, EVT_NONE);
    send(32'h45, EVT_NONE);
    wait_done("t3", 1'b0);
    bus_write(6'd1, 32'd3);

    // random output backpressure on a 7-sample window
    for (int d = 'h52; d <= 'h58; d++) expect_out(d, d == 'h56, d == 'h58);
    send(32'h50, EVT_START);
    for (int d = 'h51; d <= 'h55; d++) send(d, EVT_NONE);
    send(32'h56, EVT_TRIG);
    send(32'h57, EVT_NONE);
    send(32'h58, EVT_NONE);
    wait_done("t4", 1'b1);

    // pre=10 pst=10 in a 16-deep ring: post truncated to 6
    bus_write(6'd0, 32'd10);
    bus_write(6'd1, 32'd10);
    for (int d = 'h62; d <= 'h71; d++) expect_out(d, d == 'h6C, d == 'h71);
    send(32'h60, EVT_START);
    for (int d = 'h61; d <= 'h6B; d++) send(d, EVT_NONE);
    send(32'h6C, EVT_TRIG);
    for (int d = 'h6D; d <= 'h71; d++) send(d, EVT_NONE);
    check("t5_truncate", sti_tready, 0);
    wait_done("t5", 1'b0);

    // reset in the middle of READ with the output stalled
    bus_write(6'd0, 32'd4);
    bus_write(6'd1, 32'd3);
    sto_tready = 1'b0;
    send(32'h80, EVT_START);
    send(32'h81, EVT_NONE);
    send(32'h82, EVT_TRIG);
    send(32'h83, EVT_NONE);
    send(32'h84, EVT_NONE);
    repeat (4) tick();
    check("t6_stalled", {sto_tvalid, sts_busy, sti_tready}, 3'b110);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check("t6_rst_out", {sto_tvalid, sto_tlast, sto_ttrig, sto_tdata}, '0);
    check("t6_rst_status", {sts_busy, sti_tready}, 2'b01);
    rst = 1'b0;
    sto_tready = 1'b1;
    mon_en = 1'b1;
    tick();

    // soft clear during FILL wins over a same-cycle trigger transfer
    bus_write(6'd0, 32'd4);
    bus_write(6'd1, 32'd3);
    send(32'h90, EVT_START);
    send(32'h91, EVT_NONE);
    bus_wvalid = 1'b1; bus_waddr = 6'd2; bus_wdata = 32'd1;
    sti_tvalid = 1'b1; sti_tdata = 32'h92; sti_tevent = EVT_TRIG;
    tick();
    check("t6_clr_fill", {sto_tvalid, sts_busy, sti_tready}, 3'b001);
    sti_tdata = 32'h93; sti_tevent = EVT_START;
    tick();
    bus_wvalid = 1'b0; sti_tvalid = 1'b0; sti_tevent = EVT_NONE;
    check("t6_clr_start", sts_busy, 0);
    for (int d = 'hA0; d <= 'hA3; d++) expect_out(d, d == 'hA1, d == 'hA3);
    send(32'hA0, EVT_START);
    send(32'hA1, EVT_TRIG);
    send(32'hA2, EVT_NONE);
    send(32'hA3, EVT_NONE);
    wait_done("t6", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
